// File: rtl/serial_arith_pkg.sv
// Shared types and limits for the bit-serial arithmetic controllers.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_t;

  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/done handshake bundle between a requester/consumer and serial_add_ctrl.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             ovf;
  logic             busy;

  modport master (
    output start_valid, a, b, c_in, sub, done_ready,
    input  start_ready, done_valid, result, c_out, ovf, busy
  );

  modport slave (
    input  start_valid, a, b, c_in, sub, done_ready,
    output start_ready, done_valid, result, c_out, ovf, busy
  );
endinterface

// File: rtl/FULL_ADDER.sv
// One-bit full adder used as the time-shared bit slice.
module FULL_ADDER (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one full adder reused over WIDTH cycles, LSB first.
// Result appears WIDTH cycles after accept and is held in DONE until taken.
module serial_add_ctrl
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_add_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  ser_state_t        state;
  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic [WIDTH-1:0]  result_q;
  logic [CNT_W-1:0]  cnt;
  logic              carry;
  logic              c_out_q;
  logic              ovf_q;
  logic              fa_sum;
  logic              fa_cout;
  logic              accept;
  logic              last_bit;

  FULL_ADDER u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .c_in (carry),
    .sum  (fa_sum),
    .c_out(fa_cout)
  );

  assign accept   = bus.start_valid && (state == IDLE);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      result_q <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Subtraction is A + ~B + 1, so c_in is overridden.
            a_sh  <= bus.a;
            b_sh  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub | bus.c_in;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          result_q <= {fa_sum, result_q[WIDTH-1:1]};
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          carry    <= fa_cout;
          cnt      <= cnt + CNT_W'(1);
          if (last_bit) begin
            // carry here is still the carry into the MSB slice.
            c_out_q <= fa_cout;
            ovf_q   <= carry ^ fa_cout;
            state   <= DONE;
          end
        end
        DONE: begin
          if (bus.done_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.start_ready = (state == IDLE);
  assign bus.done_valid  = (state == DONE);
  assign bus.busy        = (state != IDLE);
  assign bus.result      = result_q;
  assign bus.c_out       = c_out_q;
  assign bus.ovf         = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  typedef struct {
    logic [7:0] r;
    logic       co;
    logic       ov;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;
  exp_t sb[$];

  serial_add_ctrl_if #(.WIDTH(8)) bus ();

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [7:0] ia, ib, input logic ic, is);
    exp_t       e;
    logic [7:0] bb;
    logic       cc;
    logic [8:0] full;
    logic [7:0] low;
    bb   = is ? ~ib : ib;
    cc   = is ? 1'b1 : ic;
    full = {1'b0, ia} + {1'b0, bb} + {8'd0, cc};
    low  = {1'b0, ia[6:0]} + {1'b0, bb[6:0]} + {7'd0, cc};
    e.r  = full[7:0];
    e.co = full[8];
    e.ov = low[7] ^ full[8];
    return e;
  endfunction

  task automatic start_op(input logic [7:0] ia, ib, input logic ic, is);
    int n;
    bus.a = ia;
    bus.b = ib;
    bus.c_in = ic;
    bus.sub = is;
    bus.start_valid = 1'b1;
    n = 0;
    while (bus.start_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_done();
    bus.done_ready = 1'b1;
    @(posedge clk); #1;
    bus.done_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (bus.start_ready !== 1'b1) begin bad++; $display("FAIL reset_start_ready: got %b want 1", bus.start_ready); end
    total++; if (bus.done_valid !== 1'b0) begin bad++; $display("FAIL reset_done_valid: got %b want 0", bus.done_valid); end
    total++; if (bus.result !== 8'h00) begin bad++; $display("FAIL reset_result: got %h want 00", bus.result); end
    total++; if ({bus.c_out, bus.ovf, bus.busy} !== 3'b000) begin bad++; $display("FAIL reset_cout_ovf_busy: got %b want 000", {bus.c_out, bus.ovf, bus.busy}); end
  endtask

  task automatic test_ops(input string name, input logic [7:0] ta[], input logic [7:0] tb[], input logic tc[], input logic ts[]);
    int   lat;
    exp_t e;
    for (int i = 0; i < ta.size(); i++) begin
      sb.push_back(model(ta[i], tb[i], tc[i], ts[i]));
      start_op(ta[i], tb[i], tc[i], ts[i]);
      total++; if (bus.busy !== 1'b1 || bus.start_ready !== 1'b0) begin bad++; $display("FAIL %s_busy[%0d]: got busy=%b rdy=%b want 1/0", name, i, bus.busy, bus.start_ready); end
      wait_done(lat);
      total++; if (lat !== 8) begin bad++; $display("FAIL %s_latency[%0d]: got %0d want 8", name, i, lat); end
      e = sb.pop_front();
      total++; if (bus.result !== e.r) begin bad++; $display("FAIL %s_result[%0d]: got %h want %h", name, i, bus.result, e.r); end
      total++; if ({bus.c_out, bus.ovf} !== {e.co, e.ov}) begin bad++; $display("FAIL %s_cout_ovf[%0d]: got %b%b want %b%b", name, i, bus.c_out, bus.ovf, e.co, e.ov); end
      take_done();
      total++; if (bus.done_valid !== 1'b0 || bus.start_ready !== 1'b1 || bus.result !== e.r) begin bad++; $display("FAIL %s_idle_hold[%0d]: got dv=%b rdy=%b res=%h want 0/1/%h", name, i, bus.done_valid, bus.start_ready, bus.result, e.r); end
    end
  endtask

  task automatic test_add();
    test_ops("add", '{8'h00, 8'hFF, 8'h7F}, '{8'h00, 8'h01, 8'h01}, '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0});
  endtask

  task automatic test_sub();
    test_ops("sub", '{8'h05, 8'h05, 8'h80}, '{8'h07, 8'h07, 8'h01}, '{1'b1, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b1});
  endtask

  task automatic test_stall();
    int   lat;
    exp_t e;
    sb.push_back(model(8'h80, 8'h80, 1'b0, 1'b0));
    start_op(8'h80, 8'h80, 1'b0, 1'b0);
    wait_done(lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL stall_latency: got %0d want 8", lat); end
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      total++; if (bus.result !== e.r || bus.c_out !== e.co || bus.ovf !== e.ov) begin bad++; $display("FAIL stall_frozen[%0d]: got %h/%b/%b want %h/%b/%b", k, bus.result, bus.c_out, bus.ovf, e.r, e.co, e.ov); end
      total++; if (bus.start_ready !== 1'b0 || bus.done_valid !== 1'b1) begin bad++; $display("FAIL stall_hs[%0d]: got rdy=%b dv=%b want 0/1", k, bus.start_ready, bus.done_valid); end
      if (k == 1) begin
        bus.a = 8'h11; bus.b = 8'h22; bus.sub = 1'b0; bus.c_in = 1'b0;
        bus.start_valid = 1'b1;
      end else begin
        bus.start_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    take_done();
    total++; if (bus.done_valid !== 1'b0 || bus.start_ready !== 1'b1) begin bad++; $display("FAIL stall_release: got dv=%b rdy=%b want 0/1", bus.done_valid, bus.start_ready); end
    repeat (3) begin @(posedge clk); #1; end
    total++; if (bus.busy !== 1'b0 || bus.result !== e.r) begin bad++; $display("FAIL stall_no_accept: got busy=%b res=%h want 0/%h", bus.busy, bus.result, e.r); end
  endtask

  task automatic test_abort();
    int   lat;
    exp_t e;
    sb.push_back(model(8'h12, 8'h34, 1'b0, 1'b0));
    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    void'(sb.pop_front());
    total++; if ({bus.done_valid, bus.c_out, bus.ovf, bus.busy} !== 4'b0000 || bus.result !== 8'h00) begin bad++; $display("FAIL abort_outputs: got dv/co/ov/busy=%b res=%h want 0000/00", {bus.done_valid, bus.c_out, bus.ovf, bus.busy}, bus.result); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.start_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", bus.start_ready); end
    sb.push_back(model(8'h12, 8'h34, 1'b0, 1'b0));
    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    wait_done(lat);
    e = sb.pop_front();
    total++; if (lat !== 8 || bus.result !== e.r || bus.result !== 8'h46) begin bad++; $display("FAIL abort_rerun: got lat=%0d res=%h want 8/46", lat, bus.result); end
    take_done();
  endtask

  task automatic test_back_to_back();
    int   n;
    int   lat;
    int   acc_prev;
    exp_t e;
    logic [7:0] ia;
    logic [7:0] ib;
    acc_prev = 0;
    bus.done_ready = 1'b1;
    bus.start_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ia = {7'd0, i[0]};
      ib = {7'd0, i[1]};
      bus.a = ia; bus.b = ib; bus.c_in = i[2]; bus.sub = 1'b0;
      n = 0;
      while (bus.start_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      sb.push_back(model(ia, ib, i[2], 1'b0));
      @(posedge clk); #1;
      if (i > 0) begin
        total++; if (cyc - acc_prev !== 10) begin bad++; $display("FAIL b2b_spacing[%0d]: got %0d want 10", i, cyc - acc_prev); end
      end
      acc_prev = cyc;
      wait_done(lat);
      e = sb.pop_front();
      total++; if (lat !== 8 || bus.result !== e.r || bus.c_out !== e.co || bus.ovf !== e.ov) begin bad++; $display("FAIL b2b_op[%0d]: got lat=%0d res=%h co=%b ov=%b want 8/%h/%b/%b", i, lat, bus.result, bus.c_out, bus.ovf, e.r, e.co, e.ov); end
      total++; if (bus.result[1:0] !== {(i[0] & i[1]) | (i[2] & (i[0] ^ i[1])), i[0] ^ i[1] ^ i[2]}) begin bad++; $display("FAIL b2b_truth[%0d]: got %b", i, bus.result[1:0]); end
    end
    bus.start_valid = 1'b0;
    @(posedge clk); #1;
    bus.done_ready = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.start_valid = 1'b0;
    bus.done_ready = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    bus.c_in = 1'b0;
    bus.sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_sub();
    test_stall();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
